counter_monitor: RTL and testbench
==================================

# counter_monitor

Passive checker for the free-running counter's `value` bus. It samples `value` every clock, locks onto an incrementing sequence, and then flags any deviation from modulo-2^WIDTH increment. It reports wrap events and keeps a saturating error count. It sits beside the counter as the consuming end of its output interface, on the same clock and reset, in both simulation and silicon self-check builds.

## Interface
Parameters:
- `WIDTH`, default 8: width of the monitored `value` bus.
- `SYNC_COUNT`, default 2: consecutive correct increments required to declare lock (range 1..15).
- `ERR_W`, default 8: width of the saturating error counter.

Ports:
- `clk` input 1: single clock; all sampling on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `value` input WIDTH: counter output under observation.
- `enable` input 1: monitor enable; low forces IDLE.
- `err_clear` input 1: synchronous clear of `err_count`.
- `locked` output 1: high while in LOCKED.
- `error` output 1: one-cycle pulse per detected mismatch.
- `wrap` output 1: one-cycle pulse per observed all-ones to zero transition while LOCKED.
- `err_count` output ERR_W: saturating mismatch count.
- `expected` output WIDTH: next value predicted, always `prev + 1` mod 2^WIDTH.

## Operation
- Internal registers:
  - `prev` (WIDTH): last sampled value.
  - `run` (4 bits): consecutive-increment count.
  - `state`: IDLE, ACQUIRE or LOCKED.
- A good step is `value == prev + 1` (mod 2^WIDTH). On every enabled edge, `prev <= value`.
- IDLE:
  - On an edge with `enable=1`: capture `prev`, set `run=0`, go to ACQUIRE.
  - No flags are raised.
- ACQUIRE:
  - Good step: increment `run`. If the new `run` equals SYNC_COUNT, go to LOCKED and assert `locked`.
  - Bad step: `run <= 0`, stay in ACQUIRE. This is not an error; lock has not yet been claimed.
- LOCKED:
  - Good step: stay in LOCKED. If `prev` is all ones and `value` is 0, pulse `wrap`.
  - Bad step: pulse `error`, increment `err_count`, deassert `locked`, set `run=0`, go to ACQUIRE.
- `enable=0` in any state: go to IDLE on the next edge with `locked=0`. `err_count` and `prev` are held.
- `err_count`:
  - Increments by 1 per error and saturates at 2^ERR_W-1; it never wraps.
  - `err_clear` clears it. If `err_clear` and an error occur on the same edge, the result is 1.
- Arithmetic: all value comparisons are WIDTH-bit modulo. `expected` wraps from all ones to 0.

## Timing
- All outputs are registered. They update on the edge that samples the triggering `value` and hold until the next edge.
- Lock latency after enable: 1 capture edge plus SYNC_COUNT good steps. With the default, `locked` rises on the 3rd enabled edge.
- Error latency: `error` is high for exactly the one cycle following the sampling edge of the bad value.
- `wrap` and `error` are never high together.
- Reset values (asynchronous, immediate):
  - `locked=0`, `error=0`, `wrap=0`, `err_count=0`
  - `prev` = all ones, so `expected` = 0
  - `run=0`, state IDLE
- Reset asserted mid-lock: all of the above apply immediately, with no pulse emitted. After reset release the block re-acquires from IDLE.

## Configuration
- `COUNTER_MONITOR_HOLD_EN` defined:
  - In LOCKED, `value == prev` is a stall. No error, `run` is unchanged, and `expected` is unchanged.
  - In ACQUIRE, a stall leaves `run` unchanged.
- `COUNTER_MONITOR_HOLD_EN` undefined: a repeated value is a bad step, with the normal ACQUIRE and LOCKED handling.

## Test plan
- Reset pulse, then `enable=1` with `value` sequence 0x00,0x01,0x02,0x03 -> `locked` rises after the edge sampling 0x02; `error=0`; `expected=0x03` after that edge.
- Locked at 0x10, then inject 0x05 and continue 0x06,0x07 -> `error` high one cycle after 0x05; `err_count=1`; `locked` low; `locked` high again after the edge sampling 0x07.
- Locked sequence 0xFE,0xFF,0x00,0x01 -> `wrap` pulses once after the edge sampling 0x00; `error=0`; `expected=0x01` after that edge.
- Locked, `value` 0x20,0x20,0x21 -> with `COUNTER_MONITOR_HOLD_EN`: no error and `locked` stays high. Without it: `error` pulse on the second 0x20 and `err_count=1`.
- ERR_W=2, four lock/error cycles -> `err_count` reads 1,2,3,3. Then `err_clear` on the same edge as a fifth error -> `err_count=1`.
- Locked at 0x40, assert `reset` between clock edges -> `locked`, `err_count` and `error` go to 0 and `expected` to 0x00 before the next edge. After release, lock re-acquires from IDLE per the first test.

Source files
------------

// File: rtl/counter_monitor.sv
// Passive lock-and-check monitor for a free-running modulo-2^WIDTH counter bus.
// Optional build macro COUNTER_MONITOR_HOLD_EN treats a repeated value as a stall rather than an error.
module counter_monitor #(
  parameter int WIDTH      = 8,
  parameter int SYNC_COUNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic             enable,
  input  logic             err_clear,
  output logic             locked,
  output logic             error,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  localparam logic [3:0]       SYNC    = 4'(SYNC_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [3:0]       run;
  logic             good;
  logic             stall;
  logic             err_hit;

  assign good = (value == prev + WIDTH'(1));

`ifdef COUNTER_MONITOR_HOLD_EN
  assign stall = (value == prev);
`else
  assign stall = 1'b0;
`endif

  // Only a claimed lock can be broken; misses during acquisition are silent.
  assign err_hit = enable && (state == LOCKED) && !good && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= '1;
      expected  <= '0;
      run       <= '0;
      locked    <= 1'b0;
      error     <= 1'b0;
      wrap      <= 1'b0;
      err_count <= '0;
    end else begin
      error <= 1'b0;
      wrap  <= 1'b0;

      // A clear coinciding with an error leaves that error counted.
      if (err_clear)
        err_count <= ERR_W'(err_hit);
      else if (err_hit && err_count != ERR_MAX)
        err_count <= err_count + ERR_W'(1);

      if (!enable) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        prev     <= value;
        expected <= value + WIDTH'(1);
        case (state)
          IDLE: begin
            run   <= '0;
            state <= ACQUIRE;
          end
          ACQUIRE: begin
            if (good) begin
              run <= run + 4'd1;
              if (run + 4'd1 == SYNC) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (!stall) begin
              run <= '0;
            end
          end
          LOCKED: begin
            if (good) begin
              wrap <= (prev == '1) && (value == '0);
            end else if (!stall) begin
              error  <= 1'b1;
              locked <= 1'b0;
              run    <= '0;
              state  <= ACQUIRE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_monitor.sv
// Scoreboard bench for counter_monitor: directed scenarios plus random counter streams
// checked against an arithmetic reference model.
module tb_counter_monitor;
  localparam int W   = 8;
  localparam int SC  = 2;
  localparam int EW  = 2;
  localparam int MOD = 1 << W;
  localparam int SAT = (1 << EW) - 1;
`ifdef COUNTER_MONITOR_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          err_clear = 1'b0;
  logic [W-1:0]  value = '0;
  logic          locked, error, wrap;
  logic [EW-1:0] err_count;
  logic [W-1:0]  expected;

  counter_monitor #(.WIDTH(W), .SYNC_COUNT(SC), .ERR_W(EW)) dut (
    .clk(clk), .reset(reset), .value(value), .enable(enable), .err_clear(err_clear),
    .locked(locked), .error(error), .wrap(wrap), .err_count(err_count), .expected(expected)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lk;
    bit er;
    bit wr;
    int cnt;
    int ex;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: last sample, whether a first sample was taken since enable,
  // current streak of good steps, lock flag and error tally.
  int m_last = MOD - 1;
  int m_streak = 0;
  int m_cnt = 0;
  bit m_have = 0;
  bit m_lock = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("locked", int'(locked), int'(e.lk));
        chk("error", int'(error), int'(e.er));
        chk("wrap", int'(wrap), int'(e.wr));
        chk("err_count", int'(err_count), e.cnt);
        chk("expected", int'(expected), e.ex);
        chk("wrap_error_excl", int'(wrap && error), 0);
      end
    end
  end

  task automatic step(input bit rst, input bit en, input bit clr, input int val);
    bit   e_flag, w_flag, good, stall;
    exp_t x;
    @(negedge clk);
    reset     = rst;
    enable    = en;
    err_clear = clr;
    value     = W'(val);
    e_flag = 0;
    w_flag = 0;
    val    = val % MOD;
    if (rst) begin
      m_last = MOD - 1; m_have = 0; m_lock = 0; m_streak = 0; m_cnt = 0;
    end else begin
      if (!en) begin
        m_have = 0;
        m_lock = 0;
      end else begin
        good  = (val == (m_last + 1) % MOD);
        stall = HOLD && (val == m_last);
        if (!m_have) begin
          m_have = 1;
          m_streak = 0;
        end else if (m_lock) begin
          if (good) w_flag = (m_last == MOD - 1) && (val == 0);
          else if (!stall) begin e_flag = 1; m_lock = 0; m_streak = 0; end
        end else if (good) begin
          m_streak++;
          if (m_streak == SC) m_lock = 1;
        end else if (!stall) begin
          m_streak = 0;
        end
        m_last = val;
      end
      if (clr) m_cnt = int'(e_flag);
      else if (e_flag) m_cnt = (m_cnt + 1 > SAT) ? SAT : m_cnt + 1;
    end
    x.lk = m_lock; x.er = e_flag; x.wr = w_flag; x.cnt = m_cnt; x.ex = (m_last + 1) % MOD;
    q.push_back(x);
    if (rst) begin
      // Reset must clear outputs before the next clock edge.
      #1;
      chk("rst_locked", int'(locked), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_err_count", int'(err_count), 0);
      chk("rst_expected", int'(expected), 0);
    end
  endtask

  initial begin : stim
    int cur;
    int r;
    int t;
    #1 reset = 1'b1;
    #1;
    chk("init_locked", int'(locked), 0);
    chk("init_wrap", int'(wrap), 0);
    chk("init_err_count", int'(err_count), 0);
    chk("init_expected", int'(expected), 0);
    step(1, 0, 0, 0);

    // Lock from zero: locked after the edge sampling 0x02.
    for (int v = 0; v < 4; v++) step(0, 1, 0, v);
    // Lock at 0x10, glitch to 0x05, re-lock at 0x07.
    step(0, 0, 0, 0);
    for (int v = 'h0E; v <= 'h10; v++) step(0, 1, 0, v);
    for (int v = 'h05; v <= 'h08; v++) step(0, 1, 0, v);
    // Wrap through all-ones.
    step(0, 0, 0, 0);
    for (int v = 'hFC; v <= 'h101; v++) step(0, 1, 0, v);
    // Repeated value while locked.
    for (int v = 'h1E; v <= 'h20; v++) step(0, 1, 0, v);
    for (int v = 'h20; v <= 'h23; v++) step(0, 1, 0, v);
    // Saturation: four error/re-lock cycles, then clear with a fifth error.
    step(0, 1, 1, 'h24);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 'h80 + k * 16);
      step(0, 1, 0, 'h81 + k * 16);
      step(0, 1, 0, 'h82 + k * 16);
    end
    step(0, 1, 1, 'hF0);
    // Reset while locked at 0x40, then re-acquire from zero.
    for (int v = 'h3E; v <= 'h40; v++) step(0, 1, 0, v);
    step(1, 1, 0, 'h41);
    step(1, 1, 0, 'h42);
    for (int v = 0; v < 4; v++) step(0, 1, 0, v);

    cur = 'h37;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) cur = $urandom_range(0, MOD - 1);
      else if (r >= 10) cur = (cur + 1) % MOD;
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) < 96),
           ($urandom_range(0, 99) < 3), cur);
    end

    t = 0;
    while (q.size() > 0 && t < 10) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
